// File: rtl/apb_master.sv
// APB initiator: turns single-beat command-port requests into APB transfers, one at a time,
// and aborts any transfer whose PREADY does not arrive within TIMEOUT ACCESS samples.
module apb_master #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                // PREADY is tested first so a completion on the last allowed sample wins
                if (PREADY) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = StIdle;
                end else if (cnt_q == CntMax) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        unique case (state_q)
            StIdle:   cmd_ready = 1'b1;
            StSetup:  PSEL      = 1'b1;
            StAccess: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and random transfers checked against a per-transfer
// outcome model (latency, timeout flag, read data) derived from the number of wait states.
module tb_apb_master;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PWRITE, PSEL, PENABLE, PREADY;
    logic [DW-1:0] PWDATA, PRDATA;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int prev_hs = -100;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge. waits = PREADY-low ACCESS samples before PREADY rises.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] rd, input bit hold, input bit b2b);
        bit            exp_to;
        int            exp_lat;
        logic [DW-1:0] exp_rd;
        int            hs;
        int            bound;
        bit            got;
        exp_to  = (waits >= int'(TO));
        exp_lat = 1 + (exp_to ? int'(TO) : waits + 1);
        exp_rd  = (wr || exp_to) ? '0 : rd;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        PREADY    = 1'b0;
        bound = 0;
        while (!cmd_ready && bound < 50) begin
            @(negedge PCLK);
            bound++;
        end
        check("cmd_ready_before_hs", 64'(cmd_ready), 64'(1));
        @(negedge PCLK);
        hs = cyc;
        if (b2b) check("b2b_spacing", 64'(hs - prev_hs), 64'(3));
        prev_hs = hs;
        check("setup_sel_en", 64'({PSEL, PENABLE, cmd_ready}), 64'(3'b100));
        check("setup_bus", 64'({PADDR, PWRITE, PWDATA}), 64'({a, wr, wd}));
        if (!hold) cmd_valid = 1'b0;

        got = 1'b0;
        for (int k = 0; k < int'(TO) + 4 && !got; k++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                check("access_bus", 64'({PSEL, PENABLE, PADDR, PWRITE, PWDATA}),
                      64'({2'b11, a, wr, wd}));
                PREADY = (k == waits);
                PRDATA = (k == waits) ? rd : $urandom;
            end
        end
        PREADY = 1'b0;
        check("rsp_seen", 64'(got), 64'(1));
        check("rsp_latency", 64'(cyc - hs), 64'(exp_lat));
        check("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_idle", 64'({PSEL, PENABLE, cmd_ready}), 64'(3'b001));
        if (!hold) begin
            @(negedge PCLK);
            check("rsp_pulse_end", 64'(rsp_valid), 64'(0));
            check("rsp_rdata_hold", 64'(rsp_rdata), 64'(exp_rd));
            check("bus_hold_idle", 64'({PSEL, PADDR, PWRITE, PWDATA}), 64'({1'b0, a, wr, wd}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        #12;
        check("reset_outputs", 64'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_timeout}), 64'(0));
        check("reset_data", 64'({PADDR, PWDATA}), 64'(0));
        check("reset_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));

        xfer(1'b1, 4'd3, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 4'd5, 32'h0, 2, 32'h12345678, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++)
            xfer(1'b1, AW'(i), $urandom, 0, 32'h0, (i != 3), (i != 0));

        xfer(1'b0, 4'd7, $urandom, int'(TO), $urandom, 1'b0, 1'b0);
        xfer(1'b0, 4'd8, $urandom, int'(TO) - 1, 32'hA5A5_0F0F, 1'b0, 1'b0);

        // Reset during wait states: bus and response collapse at once, nothing is reported.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd9;
        cmd_wdata = 32'hCAFEF00D;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        check("pre_reset_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        #2 PRESETn = 1'b0;
        #1;
        check("async_reset_bus", 64'({PSEL, PENABLE, rsp_valid, PWRITE}), 64'(0));
        check("async_reset_data", 64'({PADDR, PWDATA}), 64'(0));
        @(negedge PCLK);
        PRESETn = 1'b1;
        seen = 1'b0;
        repeat (int'(TO) + 4) begin
            @(negedge PCLK);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_reset", 64'(seen), 64'(0));
        xfer(1'b1, 4'd2, 32'h0BADCAFE, 1, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++)
            xfer(1'($urandom_range(1)), AW'($urandom), $urandom,
                 int'($urandom_range(TO + 2)), $urandom, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
